// File: rtl/bop_round_ctrl.sv
// Round sequencer for the bop-it gamepad: issues a command, arms it once inputs are released,
// judges the response against the 1 Hz tick and keeps a saturating BCD score.
module bop_round_ctrl #(
   parameter int NUM_CMDS    = 12,
   parameter int TIMEOUT_S   = 10,
   parameter int WIN_DELAY_S = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       start,
   input  logic [4:0] rand_in,
   input  logic [7:0] sw,
   input  logic [3:0] btn,
   output logic [3:0] cmd_code,
   output logic       game_on,
   output logic       round_won,
   output logic [1:0] fail_reason,
   output logic [3:0] secs_ones,
   output logic [3:0] secs_tens,
   output logic [3:0] score_ones,
   output logic [3:0] score_tens,
   output logic [7:0] led
);

   typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT, S_WON, S_OVER} state_t;

   localparam logic [3:0] TO_TENS  = 4'(TIMEOUT_S / 10);
   localparam logic [3:0] TO_ONES  = 4'(TIMEOUT_S % 10);
   localparam logic [7:0] DLY_LAST = 8'(WIN_DELAY_S - 1);

   state_t      state_reg;
   logic        start_q;
   logic [7:0]  delay_reg;

   logic [11:0] all_in;
   logic [11:0] sel_mask;
   logic        any_act;
   logic        correct;
   logic        wrong;
   logic        start_edge;
   logic [3:0]  new_cmd;
   logic [3:0]  secs_ones_inc;
   logic [3:0]  secs_tens_inc;
   logic        timeout_hit;
   logic        score_max;
   logic [3:0]  score_ones_inc;
   logic [3:0]  score_tens_inc;

   // Inputs packed so the command code indexes straight into them: sw in 0-7, buttons in 8-11.
   assign all_in = {btn, sw};

   generate
      for (genvar gi = 0; gi < 12; gi++) begin : g_sel
         assign sel_mask[gi] = (cmd_code == 4'(gi));
      end
   endgenerate

   assign any_act    = |all_in;
   assign correct    = |(all_in & sel_mask);
   assign wrong      = |(all_in & ~sel_mask);
   assign start_edge = start & ~start_q;
   assign new_cmd    = 4'(rand_in % 5'(NUM_CMDS));

   assign secs_ones_inc = (secs_ones == 4'd9) ? 4'd0 : secs_ones + 4'd1;
   assign secs_tens_inc = (secs_ones == 4'd9) ? secs_tens + 4'd1 : secs_tens;
   assign timeout_hit   = (secs_tens_inc == TO_TENS) && (secs_ones_inc == TO_ONES);

   assign score_max      = (score_tens == 4'd9) && (score_ones == 4'd9);
   assign score_ones_inc = score_max ? 4'd9 : ((score_ones == 4'd9) ? 4'd0 : score_ones + 4'd1);
   assign score_tens_inc = score_max ? 4'd9 : ((score_ones == 4'd9) ? score_tens + 4'd1 : score_tens);

   function automatic logic [7:0] prompt(input logic [3:0] c);
      return (c < 4'd8) ? (8'd1 << c[2:0]) : 8'd0;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= S_IDLE;
         start_q     <= 1'b1;
         delay_reg   <= 8'd0;
         cmd_code    <= 4'd0;
         game_on     <= 1'b0;
         round_won   <= 1'b0;
         fail_reason <= 2'd0;
         secs_ones   <= 4'd0;
         secs_tens   <= 4'd0;
         score_ones  <= 4'd0;
         score_tens  <= 4'd0;
         led         <= 8'd0;
      end else begin
         start_q <= start;
         if (start_edge) begin
            state_reg   <= S_ARM;
            delay_reg   <= 8'd0;
            cmd_code    <= new_cmd;
            game_on     <= 1'b1;
            round_won   <= 1'b0;
            fail_reason <= 2'd0;
            secs_ones   <= 4'd0;
            secs_tens   <= 4'd0;
            score_ones  <= 4'd0;
            score_tens  <= 4'd0;
            led         <= prompt(new_cmd);
         end else begin
            case (state_reg)
               S_ARM: begin
                  if (!any_act)
                     state_reg <= S_WAIT;
                  // A timeout on the same tick overrides the release.
                  if (tick_1hz) begin
                     secs_ones <= secs_ones_inc;
                     secs_tens <= secs_tens_inc;
                     if (timeout_hit) begin
                        state_reg   <= S_OVER;
                        fail_reason <= 2'd2;
                        game_on     <= 1'b0;
                        led         <= 8'd0;
                     end
                  end
               end
               S_WAIT: begin
                  if (wrong) begin
                     state_reg   <= S_OVER;
                     fail_reason <= 2'd1;
                     game_on     <= 1'b0;
                     led         <= 8'd0;
                  end else if (correct) begin
                     state_reg  <= S_WON;
                     round_won  <= 1'b1;
                     delay_reg  <= 8'd0;
                     secs_ones  <= 4'd0;
                     secs_tens  <= 4'd0;
                     score_ones <= score_ones_inc;
                     score_tens <= score_tens_inc;
                     led        <= 8'd0;
                  end else if (tick_1hz) begin
                     secs_ones <= secs_ones_inc;
                     secs_tens <= secs_tens_inc;
                     if (timeout_hit) begin
                        state_reg   <= S_OVER;
                        fail_reason <= 2'd2;
                        game_on     <= 1'b0;
                        led         <= 8'd0;
                     end
                  end
               end
               S_WON: begin
                  if (tick_1hz) begin
                     if (delay_reg == DLY_LAST) begin
                        state_reg <= S_ARM;
                        delay_reg <= 8'd0;
                        cmd_code  <= new_cmd;
                        round_won <= 1'b0;
                        led       <= prompt(new_cmd);
                     end else begin
                        delay_reg <= delay_reg + 8'd1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bop_round_ctrl.sv
// Directed bench for bop_round_ctrl: walks a game through wins, wrong inputs, timeouts,
// score saturation, restart and reset-with-start-held.
module tb_bop_round_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick_1hz;
   logic       start;
   logic [4:0] rand_in;
   logic [7:0] sw;
   logic [3:0] btn;
   logic [3:0] cmd_code;
   logic       game_on;
   logic       round_won;
   logic [1:0] fail_reason;
   logic [3:0] secs_ones;
   logic [3:0] secs_tens;
   logic [3:0] score_ones;
   logic [3:0] score_tens;
   logic [7:0] led;

   int n_checks = 0;
   int n_errors = 0;

   bop_round_ctrl #(.NUM_CMDS(12), .TIMEOUT_S(10), .WIN_DELAY_S(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .tick_1hz    (tick_1hz),
      .start       (start),
      .rand_in     (rand_in),
      .sw          (sw),
      .btn         (btn),
      .cmd_code    (cmd_code),
      .game_on     (game_on),
      .round_won   (round_won),
      .fail_reason (fail_reason),
      .secs_ones   (secs_ones),
      .secs_tens   (secs_tens),
      .score_ones  (score_ones),
      .score_tens  (score_tens),
      .led         (led)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic tk();
      tick_1hz = 1'b1;
      cyc();
      tick_1hz = 1'b0;
      cyc();
   endtask

   // From WON with rand_in=0: sit out the delay, arm, then press sw[0].
   task automatic win_round();
      tk(); tk(); tk();
      cyc();
      sw = 8'h01;
      cyc();
      sw = 8'h00;
   endtask

   initial begin
      rst = 1'b1; tick_1hz = 1'b0; start = 1'b0; rand_in = 5'd0; sw = 8'h00; btn = 4'h0;
      cyc(); cyc();
      rst = 1'b0;
      check("rst_cmd", 32'(cmd_code), 32'h0);
      check("rst_game_on", 32'(game_on), 32'h0);
      check("rst_led", 32'(led), 32'h0);
      check("rst_score", 32'({score_tens, score_ones}), 32'h00);
      check("rst_secs", 32'({secs_tens, secs_ones}), 32'h00);
      check("rst_fail", 32'(fail_reason), 32'h0);
      cyc();

      // Round 1: rand 14 -> cmd 2
      rand_in = 5'd14; start = 1'b1;
      cyc();
      start = 1'b0;
      check("r1_cmd", 32'(cmd_code), 32'h2);
      check("r1_led", 32'(led), 32'h04);
      check("r1_game_on", 32'(game_on), 32'h1);
      cyc();
      sw = 8'h04;
      cyc();
      check("r1_won", 32'(round_won), 32'h1);
      check("r1_score", 32'({score_tens, score_ones}), 32'h01);

      // Round 2: sw[2] still held through delay; rand 9 -> cmd 9 (R)
      rand_in = 5'd9;
      tk(); tk(); tk();
      check("r2_cmd", 32'(cmd_code), 32'h9);
      check("r2_led", 32'(led), 32'h00);
      check("r2_won_clr", 32'(round_won), 32'h0);
      btn = 4'b0010;
      cyc(); cyc();
      check("r2_arm_ignore_won", 32'(round_won), 32'h0);
      check("r2_arm_ignore_on", 32'(game_on), 32'h1);
      sw = 8'h00; btn = 4'h0;
      cyc();
      btn = 4'b0010;
      cyc();
      btn = 4'h0;
      check("r2_won", 32'(round_won), 32'h1);
      check("r2_score", 32'({score_tens, score_ones}), 32'h02);

      // Round 3: cmd 8 (U) with U and sw[5] together -> wrong
      rand_in = 5'd8;
      tk(); tk(); tk();
      check("r3_cmd", 32'(cmd_code), 32'h8);
      cyc();
      btn = 4'b0001; sw = 8'h20;
      cyc();
      btn = 4'h0; sw = 8'h00;
      check("r3_game_on", 32'(game_on), 32'h0);
      check("r3_fail", 32'(fail_reason), 32'h1);
      check("r3_score", 32'({score_tens, score_ones}), 32'h02);

      // Timeout round
      rand_in = 5'd3; start = 1'b1;
      cyc();
      start = 1'b0;
      check("to_score_clr", 32'({score_tens, score_ones}), 32'h00);
      check("to_fail_clr", 32'(fail_reason), 32'h0);
      check("to_led", 32'(led), 32'h08);
      cyc();
      for (int i = 0; i < 9; i++) tk();
      check("to_secs9", 32'({secs_tens, secs_ones}), 32'h09);
      check("to_on9", 32'(game_on), 32'h1);
      tk();
      check("to_secs10", 32'({secs_tens, secs_ones}), 32'h10);
      check("to_game_on", 32'(game_on), 32'h0);
      check("to_fail", 32'(fail_reason), 32'h2);

      // Tick and correct input together at secs 09 -> win
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      for (int i = 0; i < 9; i++) tk();
      tick_1hz = 1'b1; sw = 8'h08;
      cyc();
      tick_1hz = 1'b0; sw = 8'h00;
      check("tc_won", 32'(round_won), 32'h1);
      check("tc_fail", 32'(fail_reason), 32'h0);
      check("tc_secs", 32'({secs_tens, secs_ones}), 32'h00);
      check("tc_score", 32'({score_tens, score_ones}), 32'h01);

      // Score to 99 and saturation
      rand_in = 5'd0;
      for (int i = 0; i < 98; i++) begin
         win_round();
         if (i == 8) check("sc_carry", 32'({score_tens, score_ones}), 32'h10);
      end
      check("sc_99", 32'({score_tens, score_ones}), 32'h99);
      win_round();
      check("sc_sat", 32'({score_tens, score_ones}), 32'h99);
      check("sc_sat_won", 32'(round_won), 32'h1);
      tk(); tk(); tk();
      cyc();
      sw = 8'h02;
      cyc();
      sw = 8'h00;
      check("ov_fail", 32'(fail_reason), 32'h1);
      check("ov_hold_score", 32'({score_tens, score_ones}), 32'h99);

      // Restart from OVER: rand 31 -> cmd 7
      rand_in = 5'd31; start = 1'b1;
      cyc();
      check("rs_cmd", 32'(cmd_code), 32'h7);
      check("rs_led", 32'(led), 32'h80);
      check("rs_score", 32'({score_tens, score_ones}), 32'h00);
      check("rs_game_on", 32'(game_on), 32'h1);
      cyc();

      // Reset in WAIT with start held
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("rw_game_on", 32'(game_on), 32'h0);
      check("rw_cmd", 32'(cmd_code), 32'h0);
      check("rw_led", 32'(led), 32'h00);
      cyc(); cyc();
      check("rw_held_idle", 32'(game_on), 32'h0);
      start = 1'b0;
      cyc();
      rand_in = 5'd5; start = 1'b1;
      cyc();
      start = 1'b0;
      check("rw_restart_on", 32'(game_on), 32'h1);
      check("rw_restart_cmd", 32'(cmd_code), 32'h5);
      check("rw_restart_led", 32'(led), 32'h20);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bop_round_ctrl.md
Name: bop_round_ctrl

Overview:
Game-round sequencer for the bop-it gamepad. It issues a random command (switch 0-7 or button U/R/D/L) and arms the command only once all inputs are released. It then times the player's response with the 1 Hz tick, scores correct responses in BCD, and ends the game on a wrong input or a timeout. Its outputs drive the 7-segment mux (digits/anode selection stay in the display path) and the LEDs; the 1 Hz divider and random source sit outside the block.

Parameters:
NUM_CMDS, 12, number of command codes; a new command is rand_in mod NUM_CMDS
TIMEOUT_S, 10, seconds allowed per round before game over (1..99)
WIN_DELAY_S, 3, 1 Hz ticks spent in the win pause before the next command

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
tick_1hz  input  1  one-clk-wide pulse, once per second
start  input  1  start/restart request (btnS level); rising edge used internally
rand_in  input  5  free-running random value
sw  input  8  player switches
btn  input  4  player buttons: [0]=U, [1]=R, [2]=D, [3]=L
cmd_code  output  4  current command: 0-7 = sw[n], 8=U, 9=R, 10=D, 11=L
game_on  output  1  high in ARM/WAIT/WON
round_won  output  1  high in WON
fail_reason  output  2  0=none, 1=wrong input, 2=timeout; valid in OVER
secs_ones  output  4  BCD seconds elapsed in the current round
secs_tens  output  4  BCD tens of seconds
score_ones  output  4  BCD score
score_tens  output  4  BCD score tens
led  output  8  one-hot sw[cmd_code] prompt when cmd_code<8 in ARM/WAIT, else 0

Behaviour:
- All state and outputs are registered. Reset takes effect on the next clk edge and overrides everything, including mid-round.
- Reset values: state=IDLE, cmd_code=0, all BCD digits=0, fail_reason=0, led=0, game_on=0, round_won=0, start edge register=1 (a held start does not fire right after reset).
- any_act = |sw | |btn. correct = the input selected by cmd_code. wrong = any_act with any bit other than the correct one set.
- start_edge = start & ~start_q. In any state, start_edge clears the score, secs, delay counter and fail_reason, loads cmd_code = rand_in mod NUM_CMDS and enters ARM. This has priority over all other transitions.
- IDLE: waits for start_edge.
- ARM: secs counts on tick. When any_act==0 in a cycle, go to WAIT next cycle. Inputs held over from the previous round are never judged.
- WAIT, priority within one cycle:
  1. wrong -> OVER, fail_reason=1. Correct plus another input at the same time also counts as wrong.
  2. correct alone -> WON. A tick in that cycle is ignored.
  3. tick -> secs += 1 (BCD, ones wrap 9->0 with carry into tens). If the new value equals TIMEOUT_S -> OVER, fail_reason=2, and secs displays TIMEOUT_S.
- Timeout also applies in ARM: if inputs are never released, the round times out the same way.
- WON:
  - On entry, score += 1 in BCD, saturating at 99.
  - secs cleared.
  - Inputs are ignored.
  - The delay counter increments per tick. On the WIN_DELAY_S-th tick: load the new cmd_code from rand_in mod NUM_CMDS, clear the counter, go to ARM.
- OVER: game_on=0. Score, secs and fail_reason are held for display. Only start_edge or rst leaves this state.
- rand_in values >= NUM_CMDS are reduced by modulo (5-bit input, 0..31). The same command may repeat back-to-back.
- led is updated in the same cycle as cmd_code/state, with no extra latency.

Test Plan:
- rst, then start pulse with rand_in=14 -> cmd_code=2, state ARM, led=8'b00000100; sw=0 -> WAIT one cycle later; sw[2]=1 -> round_won=1 and score=01 on the next edge.
- In WON with sw[2] still held: 3 ticks with rand_in=9 -> cmd_code=9, ARM. It stays in ARM while sw[2]=1, enters WAIT after release, then btn[1] -> WON, score=02.
- WAIT with cmd_code=8: btn[0] and sw[5] asserted in the same cycle -> OVER, fail_reason=1, score unchanged.
- WAIT with no input: 10 ticks -> secs_tens=1, secs_ones=0, OVER, fail_reason=2. Tick and correct input in the same cycle at secs=09 -> WON, no timeout.
- Score preset to 99 by 99 wins -> the next win keeps 99. start_edge in OVER -> score=00, secs=00, ARM.
- rst asserted in WAIT with start held high -> IDLE, all outputs at reset values. Deassert rst with start still high -> stays IDLE until start falls and rises again.
